stream_demux4: RTL and testbench
================================

STREAM_DEMUX4 -- requirements
Module: stream_demux4

Interface
REQ-001 The module SHALL have parameter width, default 8, giving the data width in bits of the input beat and of every output channel.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: an input beat is offered.
REQ-005 Port in_ready, output, 1 bit: the block accepts the offered beat this cycle.
REQ-006 Port in_select, input, 2 bits: the destination channel index 0..3 for the offered beat.
REQ-007 Port in_data, input, width bits: the input beat payload.
REQ-008 Port out_valid, output, 4 bits: bit i means channel i holds a beat.
REQ-009 Port out_ready, input, 4 bits: bit i means the channel i consumer accepts this cycle.
REQ-010 Ports out_data0, out_data1, out_data2 and out_data3, outputs, width bits each: the payload held by each channel.
REQ-011 Port beat_count, output, 16 bits: the count of accepted input beats (see Configuration).

Function
REQ-012 Each channel i SHALL contain a one-entry register, slot i, which drives out_valid[i] and out_data<i>.
REQ-013 in_ready SHALL equal rst_n && (!out_valid[in_select] || out_ready[in_select]); it depends combinationally on in_select and out_ready only.
REQ-014 An accept SHALL occur when in_valid && in_ready; slot[in_select] then loads in_data and sets out_valid on the next edge (latency 1 cycle).
REQ-015 A drain SHALL occur on channel i when out_valid[i] && out_ready[i]; out_valid[i] then clears on the next edge unless the same slot is loaded in that cycle.
REQ-016 Simultaneous accept into channel i and drain of channel i SHALL leave out_valid[i]=1 holding the new data, which gives full throughput of 1 beat/cycle per channel.
REQ-017 While out_valid[i]=1 and out_ready[i]=0, out_data<i> SHALL remain stable.
REQ-018 Slots not selected by the current accept SHALL be unaffected by it; all four channels SHALL drain independently and concurrently.
REQ-019 A beat targeted at a full, non-draining slot SHALL stall with in_ready=0; it SHALL NOT overwrite the slot, drop the beat, or redirect to another channel.
REQ-020 When in_valid=0, in_select and in_data SHALL be ignored and no slot SHALL change except by drain.
REQ-021 out_data<i> SHALL retain its last value after a drain; only out_valid[i] is qualifying.

Reset
REQ-022 When rst_n=0 at a rising edge, the block SHALL clear out_valid to 4'b0000, every out_data<i> to 0, and beat_count to 0.
REQ-023 While rst_n=0, in_ready SHALL be 0 and no accept SHALL be counted.
REQ-024 Beats held in slots when reset is asserted SHALL be discarded, with no partial output.
REQ-025 On the first edge with rst_n=1, the block SHALL be able to accept a beat.

Configuration
REQ-026 Macro STREAM_DEMUX4_COUNT_EN, when defined: beat_count SHALL increment by 1 on each accept and wrap from 16'hFFFF to 16'h0000.
REQ-027 Macro STREAM_DEMUX4_COUNT_EN, when undefined: the beat_count port SHALL still exist, SHALL be constant 0, and no counter register SHALL be synthesized.
REQ-028 All other behaviour SHALL be identical with and without STREAM_DEMUX4_COUNT_EN.

Verification
REQ-029 Basic routing: after reset, offer in_data=8'hA5 with in_select=2 and out_ready=4'b1111 for 1 cycle -> next cycle out_valid=4'b0100, out_data2=8'hA5, then out_valid=0 a cycle later.
REQ-030 Backpressure: fill slot 1 with 8'h11 while out_ready[1]=0, then offer 8'h22 to select 1 -> in_ready=0, out_data1 holds 8'h11; raise out_ready[1] -> 8'h22 accepted the same cycle and seen next cycle.
REQ-031 Throughput: stream 8'h00..8'h0F to select 3 with out_ready[3]=1 constantly -> in_ready=1 every cycle, 16 consecutive beats on out_data3, 1-cycle delay, in order.
REQ-032 Isolation: slot 0 full and stalled, offer to select 1 -> accepted, out_valid=4'b0011, slot 0 data unchanged.
REQ-033 Reset mid-operation: slots 0 and 3 full, drive rst_n=0 for 1 cycle -> out_valid=0, all out_data=0, beat_count=0, in_ready=0 during reset.
REQ-034 Counter: with STREAM_DEMUX4_COUNT_EN defined, accept 65537 beats -> beat_count=1; with the macro undefined -> beat_count=0 throughout.

Source files
------------

// File: rtl/stream_demux4.sv
// One-in, four-out stream demux with a one-entry register per channel; optional accept counter under STREAM_DEMUX4_COUNT_EN.
// Latency 1 cycle; a beat stalls (in_ready=0) only while its target slot is full and not draining.
module stream_demux4 #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_select,
   input  logic [width-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [width-1:0] out_data0,
   output logic [width-1:0] out_data1,
   output logic [width-1:0] out_data2,
   output logic [width-1:0] out_data3,
   output logic [15:0]      beat_count
);

   logic [3:0]             valid_q, valid_d;
   logic [3:0][width-1:0]  data_q, data_d;
   logic                   accept;

   always_comb begin
      in_ready = rst_n && (!valid_q[in_select] || out_ready[in_select]);
      accept   = in_valid && in_ready;
      // A drained slot clears unless it is reloaded in the same cycle.
      valid_d  = valid_q & ~out_ready;
      data_d   = data_q;
      if (accept) begin
         valid_d[in_select] = 1'b1;
         data_d[in_select]  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];
   assign out_data3 = data_q[3];

`ifdef STREAM_DEMUX4_COUNT_EN
   logic [15:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (accept) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign beat_count = count_q;
`else
   assign beat_count = '0;
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4: inputs driven and outputs sampled on the falling edge.
module tb_stream_demux4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_select;
   logic [7:0]  in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [7:0]  out_data0, out_data1, out_data2, out_data3;
   logic [15:0] beat_count;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   stream_demux4 #(.width(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_select  (in_select),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data0  (out_data0),
      .out_data1  (out_data1),
      .out_data2  (out_data2),
      .out_data3  (out_data3),
      .beat_count (beat_count)
   );

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_select = 2'd0; in_data = 8'hFF; out_ready = 4'b0000;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      repeat (2) @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
      tests_run++;
      if ({out_data0, out_data1, out_data2, out_data3} !== 32'h0) begin
         tests_failed++; $display("FAIL reset_out_data got %h want 00000000", {out_data0, out_data1, out_data2, out_data3});
      end
      tests_run++;
      if (beat_count !== 16'h0) begin tests_failed++; $display("FAIL reset_beat_count got %h want 0000", beat_count); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_routing();
      @(negedge clk);
      in_valid = 1'b1; in_select = 2'd2; in_data = 8'hA5; out_ready = 4'b1111;
      @(negedge clk);
      in_valid = 1'b0; in_select = 2'd1; in_data = 8'h00;
      tests_run++;
      if (out_valid !== 4'b0100) begin tests_failed++; $display("FAIL route_valid got %b want 0100", out_valid); end
      tests_run++;
      if (out_data2 !== 8'hA5) begin tests_failed++; $display("FAIL route_data2 got %h want a5", out_data2); end
      tests_run++;
      if (out_data1 !== 8'h00) begin tests_failed++; $display("FAIL route_data1_untouched got %h want 00", out_data1); end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL route_drained got %b want 0000", out_valid); end
      tests_run++;
      if (out_data2 !== 8'hA5) begin tests_failed++; $display("FAIL route_data_retained got %h want a5", out_data2); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 4'b1101; in_valid = 1'b1; in_select = 2'd1; in_data = 8'h11;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
      @(negedge clk);
      in_data = 8'h22;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
      tests_run++;
      if (out_valid !== 4'b0010) begin tests_failed++; $display("FAIL bp_valid got %b want 0010", out_valid); end
      @(negedge clk);
      tests_run++;
      if (out_data1 !== 8'h11) begin tests_failed++; $display("FAIL bp_hold got %h want 11", out_data1); end
      tests_run++;
      if (out_valid !== 4'b0010) begin tests_failed++; $display("FAIL bp_no_redirect got %b want 0010", out_valid); end
      out_ready = 4'b1111;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 4'b0010 || out_data1 !== 8'h22) begin
         tests_failed++; $display("FAIL bp_new_beat got valid=%b data1=%h want 0010/22", out_valid, out_data1);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL bp_drained got %b want 0000", out_valid); end
   endtask

   task automatic test_throughput();
      out_ready = 4'b1000;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_select = 2'd3; in_data = 8'(i);
         #1;
         tests_run++;
         if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL tput_ready beat %0d got %b want 1", i, in_ready); end
         if (i > 0) begin
            tests_run++;
            if (out_valid !== 4'b1000 || out_data3 !== 8'(i - 1)) begin
               tests_failed++;
               $display("FAIL tput_out beat %0d got valid=%b data3=%h want 1000/%h", i - 1, out_valid, out_data3, 8'(i - 1));
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 4'b1000 || out_data3 !== 8'h0F) begin
         tests_failed++; $display("FAIL tput_last got valid=%b data3=%h want 1000/0f", out_valid, out_data3);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL tput_drained got %b want 0000", out_valid); end
   endtask

   task automatic test_isolation();
      @(negedge clk);
      out_ready = 4'b0000; in_valid = 1'b1; in_select = 2'd0; in_data = 8'h5A;
      @(negedge clk);
      in_select = 2'd1; in_data = 8'h3C;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL iso_ready got %b want 1", in_ready); end
      @(negedge clk);
      in_select = 2'd0; in_data = 8'h77;
      #1;
      tests_run++;
      if (out_valid !== 4'b0011) begin tests_failed++; $display("FAIL iso_valid got %b want 0011", out_valid); end
      tests_run++;
      if (out_data0 !== 8'h5A || out_data1 !== 8'h3C) begin
         tests_failed++; $display("FAIL iso_data got d0=%h d1=%h want 5a/3c", out_data0, out_data1);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL iso_full_ready got %b want 0", in_ready); end
      @(negedge clk);
      tests_run++;
      if (out_data0 !== 8'h5A) begin tests_failed++; $display("FAIL iso_no_overwrite got %h want 5a", out_data0); end
      // Channel 1 drains alone while channel 0 stays stalled.
      in_valid = 1'b0; out_ready = 4'b0010;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0001) begin tests_failed++; $display("FAIL iso_indep_drain got %b want 0001", out_valid); end
      out_ready = 4'b1111;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      out_ready = 4'b0000; in_valid = 1'b1; in_select = 2'd0; in_data = 8'hC0;
      @(negedge clk);
      in_select = 2'd3; in_data = 8'hC3;
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 4'b1001) begin tests_failed++; $display("FAIL rmid_setup got %b want 1001", out_valid); end
      rst_n = 1'b0; in_valid = 1'b1; in_select = 2'd1; in_data = 8'hEE;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_ready got %b want 0", in_ready); end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 4'b0000) begin tests_failed++; $display("FAIL rmid_valid got %b want 0000", out_valid); end
      tests_run++;
      if ({out_data0, out_data1, out_data2, out_data3} !== 32'h0) begin
         tests_failed++; $display("FAIL rmid_data got %h want 00000000", {out_data0, out_data1, out_data2, out_data3});
      end
      tests_run++;
      if (beat_count !== 16'h0) begin tests_failed++; $display("FAIL rmid_count got %h want 0000", beat_count); end
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 4'b1111;
   endtask

   task automatic test_counter();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; out_ready = 4'b1111; in_select = 2'd0; in_data = 8'h01; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
`ifdef STREAM_DEMUX4_COUNT_EN
      tests_run++;
      if (beat_count !== 16'd3) begin tests_failed++; $display("FAIL count_small got %0d want 3", beat_count); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b1;
      repeat (65537) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (beat_count !== 16'd1) begin tests_failed++; $display("FAIL count_wrap got %0d want 1", beat_count); end
`else
      tests_run++;
      if (beat_count !== 16'd0) begin tests_failed++; $display("FAIL count_disabled got %0d want 0", beat_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_throughput();
      test_isolation();
      test_reset_mid();
      test_counter();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
